freelist: RTL
=============

// Module: freelist
// PURPOSE
//  Physical-register free list for the 2-wide rename stage, upstream of the rob.
//  Supplies instr0_prd/instr1_prd to rename and reclaims commits0/1_old_prd from rob commit.
//  Keeps a speculative and an architectural head; redirect restores spec head to arch head.
//  This recovers every preg allocated by flushed instructions in one cycle.
// PARAMETERS
//  PREG_NUM      64   physical registers; must match `PREG_RANGE width
//  ARCH_REG_NUM  32   architectural registers; pregs 0..31 are initially mapped
//  FL_SIZE       PREG_NUM-ARCH_REG_NUM (32)   queue depth, power of two
// PORTS
//  clock             in   1            rising-edge clock
//  reset_n           in   1            asynchronous, active-low reset
//  instr0_alloc_req  in   1            slot0 renames and needs a new prd (valid && lrd!=0)
//  instr1_alloc_req  in   1            slot1 needs a new prd
//  alloc_ready       out  1            free_count>=2; rename may fire both slots
//  instr0_prd        out  `PREG_RANGE  prd for slot0
//  instr1_prd        out  `PREG_RANGE  prd for slot1
//  commits0_valid    in   1            rob commit port 0
//  commits0_lrd      in   `LREG_RANGE  commit 0 logical rd
//  commits0_old_prd  in   `PREG_RANGE  preg released by commit 0
//  commits1_valid    in   1            rob commit port 1
//  commits1_lrd      in   `LREG_RANGE  commit 1 logical rd
//  commits1_old_prd  in   `PREG_RANGE  preg released by commit 1
//  redirect_valid    in   1            flush of all uncommitted instructions
//  free_count        out  $clog2(FL_SIZE)+1   entries between spec head and tail
// BEHAVIOUR
//  - Storage: FL_SIZE x PREG entries in flops. Pointers spec_head, arch_head and tail carry a wrap flag.
//    Each pointer is $clog2(FL_SIZE)+1 bits. free_count = tail - spec_head, modulo 2*FL_SIZE.
//  - Reset (async): entry[i]=ARCH_REG_NUM+i; spec_head=arch_head=0; tail={1,0} (full).
//    free_count=32; alloc_ready=1; instr0_prd=32; instr1_prd=33.
//  - Read is combinational. instr0_prd=entry[spec_head].
//    instr1_prd=entry[spec_head + instr0_alloc_req], so slot1 takes the head if slot0 does not request.
//  - Alloc fires when alloc_ready && !redirect_valid. spec_head += instr0_alloc_req + instr1_alloc_req.
//    Requests while !alloc_ready are ignored and no pointer moves; rename stalls.
//  - Free condition: commitsN_valid && commitsN_lrd!=0.
//    Freed old_prd values are written compacted: entry[tail], then entry[tail+1]. tail += number freed.
//    arch_head += the same count, because each committed lrd!=0 instruction consumed one preg.
//  - Freed entries become allocatable the following cycle; there is no same-cycle bypass.
//  - Redirect: spec_head <= arch_head_next, which includes this cycle's commits. No alloc that cycle.
//    Commits in the redirect cycle are still honoured.
//  - Wrap: pointer index wraps at FL_SIZE and toggles the flag.
//  - Assertions (sim only):
//    - commits1_valid implies commits0_valid.
//    - free_count never exceeds FL_SIZE.
//    - tail never passes arch_head + FL_SIZE.
//    - preg 0 is never freed or allocated.
//  - Reset mid-operation restores the reset contents, discarding all state.
// STRUCTURE
//  - FL_SIZE, pointer width and the FL_PTR_RANGE macro go in defines.sv, next to `PREG_RANGE/`LREG_RANGE.
//  - One natural sub-module: fl_ptr. It is a wrap-flag pointer with increment-by-0/1/2 and load, used three times.
//  - Everything else stays flat in freelist.
// TESTING
//  1. Reset, no requests -> free_count=32, alloc_ready=1, instr0_prd=32, instr1_prd=33.
//  2. Both req one cycle -> next: free_count=30, instr0_prd=34, instr1_prd=35.
//  3. Only instr1 req -> instr1_prd=34 (head), consumed. Next cycle instr0_prd=35.
//  4. Drain until free_count=1 -> alloc_ready=0. Reqs held 3 cycles -> prd and free_count unchanged.
//  5. Frees:
//     - commits0 lrd=0, commits1 lrd=7 old_prd=7 -> only 7 written at tail; free_count +1 next cycle.
//     - No write occurs for lrd=0.
//  6. Redirect:
//     - From reset, alloc 4 (32..35) -> free_count=28.
//     - Commit one lrd=5 old_prd=5 -> free_count=29.
//     - Redirect -> free_count=32, instr0_prd=33.
//     - Pointers then run 40 cycles of random alloc/free and must wrap without count error.

Source files
------------

// File: rtl/freelist_pkg.sv
// Shared types and sizing for the rename-stage physical register free list.
package freelist_pkg;

  localparam int PREG_NUM     = 64;
  localparam int ARCH_REG_NUM = 32;
  localparam int LREG_NUM     = 32;
  localparam int FL_SIZE      = PREG_NUM - ARCH_REG_NUM;
  localparam int FL_IDX_W     = $clog2(FL_SIZE);
  localparam int FL_PTR_W     = FL_IDX_W + 1;
  localparam int PREG_W       = $clog2(PREG_NUM);
  localparam int LREG_W       = $clog2(LREG_NUM);

  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [LREG_W-1:0]   lreg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [FL_IDX_W-1:0] fl_idx_t;

  // Storage index of a wrap-flag pointer (drops the flag bit).
  function automatic fl_idx_t fl_index(fl_ptr_t p);
    return p[FL_IDX_W-1:0];
  endfunction

  // Number of asserted bits among two single-bit flags.
  function automatic logic [1:0] count2(logic a, logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/freelist_if.sv
// Rename / commit / redirect signal bundle between the pipeline and the free list.
interface freelist_if;
  import freelist_pkg::*;

  logic    instr0_alloc_req;
  logic    instr1_alloc_req;
  logic    alloc_ready;
  preg_t   instr0_prd;
  preg_t   instr1_prd;
  logic    commits0_valid;
  lreg_t   commits0_lrd;
  preg_t   commits0_old_prd;
  logic    commits1_valid;
  lreg_t   commits1_lrd;
  preg_t   commits1_old_prd;
  logic    redirect_valid;
  fl_ptr_t free_count;

  // Pipeline side: rename requests, rob commits and flushes.
  modport master (
    output instr0_alloc_req, instr1_alloc_req,
    output commits0_valid, commits0_lrd, commits0_old_prd,
    output commits1_valid, commits1_lrd, commits1_old_prd,
    output redirect_valid,
    input  alloc_ready, instr0_prd, instr1_prd, free_count
  );

  // Free list side.
  modport slave (
    input  instr0_alloc_req, instr1_alloc_req,
    input  commits0_valid, commits0_lrd, commits0_old_prd,
    input  commits1_valid, commits1_lrd, commits1_old_prd,
    input  redirect_valid,
    output alloc_ready, instr0_prd, instr1_prd, free_count
  );

endinterface

// File: rtl/freelist_fl_ptr.sv
// Wrap-flag queue pointer: advances by 0/1/2 or loads a new value.
// The MSB is the wrap flag; because the depth is a power of two, plain
// binary addition wraps the index and toggles the flag together.
module freelist_fl_ptr
  import freelist_pkg::*;
#(
  parameter fl_ptr_t RST_VAL = '0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_load,
  input  fl_ptr_t    i_load_val,
  input  logic [1:0] i_inc,
  output fl_ptr_t    o_ptr
);

  fl_ptr_t r_ptr;

  // Load has priority over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= RST_VAL;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else begin
      r_ptr <= r_ptr + fl_ptr_t'(i_inc);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/freelist.sv
// Physical register free list for a 2-wide rename stage.
// spec_head moves on rename, arch_head moves on commit, tail moves on free.
// A redirect snaps spec_head back to arch_head, reclaiming every preg handed
// to flushed instructions in a single cycle.
module freelist
  import freelist_pkg::*;
(
  input  logic     clock,
  input  logic     reset_n,
  freelist_if.slave fl
);

  preg_t      r_entry [FL_SIZE];

  fl_ptr_t    w_spec_head;
  fl_ptr_t    w_arch_head;
  fl_ptr_t    w_tail;
  fl_ptr_t    w_arch_head_next;
  fl_ptr_t    w_wr1_ptr;
  fl_ptr_t    w_free_count;
  logic       w_free0;
  logic       w_free1;
  logic [1:0] w_free_cnt;
  logic       w_alloc_ready;
  logic       w_alloc_fire;
  logic [1:0] w_spec_inc;

  // A commit to x0 never consumed a preg, so it releases nothing.
  assign w_free0    = fl.commits0_valid && (fl.commits0_lrd != '0);
  assign w_free1    = fl.commits1_valid && (fl.commits1_lrd != '0);
  assign w_free_cnt = count2(w_free0, w_free1);

  assign w_free_count  = w_tail - w_spec_head;
  assign w_alloc_ready = (w_free_count >= fl_ptr_t'(2));
  assign w_alloc_fire  = w_alloc_ready && !fl.redirect_valid;
  assign w_spec_inc    = w_alloc_fire ? count2(fl.instr0_alloc_req, fl.instr1_alloc_req) : 2'd0;

  // Redirect target includes commits retiring in the same cycle.
  assign w_arch_head_next = w_arch_head + fl_ptr_t'(w_free_cnt);

  // Frees are compacted: a lone commit1 free still lands at tail.
  assign w_wr1_ptr = w_tail + fl_ptr_t'(w_free0);

  freelist_fl_ptr #(.RST_VAL('0)) u_spec_head (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (fl.redirect_valid),
    .i_load_val (w_arch_head_next),
    .i_inc      (w_spec_inc),
    .o_ptr      (w_spec_head)
  );

  freelist_fl_ptr #(.RST_VAL('0)) u_arch_head (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_free_cnt),
    .o_ptr      (w_arch_head)
  );

  freelist_fl_ptr #(.RST_VAL(fl_ptr_t'(FL_SIZE))) u_tail (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_free_cnt),
    .o_ptr      (w_tail)
  );

  // Queue storage: reset holds pregs ARCH_REG_NUM.., freed pregs append at tail.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        r_entry[i] <= preg_t'(ARCH_REG_NUM + i);
      end
    end else begin
      if (w_free0) begin
        r_entry[fl_index(w_tail)] <= fl.commits0_old_prd;
      end
      if (w_free1) begin
        r_entry[fl_index(w_wr1_ptr)] <= fl.commits1_old_prd;
      end
    end
  end

  // Slot1 reads the head itself when slot0 is not renaming.
  assign fl.instr0_prd  = r_entry[fl_index(w_spec_head)];
  assign fl.instr1_prd  = r_entry[fl_index(w_spec_head + fl_ptr_t'(fl.instr0_alloc_req))];
  assign fl.alloc_ready = w_alloc_ready;
  assign fl.free_count  = w_free_count;

  a_commit_order : assert property (@(posedge clock) disable iff (!reset_n)
    fl.commits1_valid |-> fl.commits0_valid);

  a_count_bound : assert property (@(posedge clock) disable iff (!reset_n)
    w_free_count <= fl_ptr_t'(FL_SIZE));

  a_tail_bound : assert property (@(posedge clock) disable iff (!reset_n)
    (w_tail - w_arch_head) <= fl_ptr_t'(FL_SIZE));

  a_free0_nonzero : assert property (@(posedge clock) disable iff (!reset_n)
    w_free0 |-> (fl.commits0_old_prd != '0));

  a_free1_nonzero : assert property (@(posedge clock) disable iff (!reset_n)
    w_free1 |-> (fl.commits1_old_prd != '0));

  a_alloc0_nonzero : assert property (@(posedge clock) disable iff (!reset_n)
    (w_alloc_fire && fl.instr0_alloc_req) |-> (fl.instr0_prd != '0));

  a_alloc1_nonzero : assert property (@(posedge clock) disable iff (!reset_n)
    (w_alloc_fire && fl.instr1_alloc_req) |-> (fl.instr1_prd != '0));

endmodule
